fcl_tile_stream_engine: RTL and testbench

// Tiled fully-connected layer engine, successor to the fixed 20x20 batched FCL controller.
// - Computes out[j] = sat(sum_i in[i]*w[j][i] + b[j]), with optional ReLU.
// - Weights arrive as a valid/ready stream of TILE-wide row slices; results leave as a

---
 rtl/fcl_tile_stream_engine_if.sv | 27 ++
 rtl/fcl_tile_stream_engine.sv | 172 +++++++++++++++++
 tb/tb_fcl_tile_stream_engine.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fcl_tile_stream_engine_if.sv
// Weight-in and result-out valid/ready streams of the tiled FCL engine.
// The engine binds to slave; the weight DMA and the downstream consumer bind to master.
interface fcl_tile_stream_engine_if #(
  parameter int DATA_W    = 16,
  parameter int TILE      = 20,
  parameter int OUT_COUNT = 50
);
  localparam int IDX_W = $clog2(OUT_COUNT);

  logic                         w_valid;
  logic                         w_ready;
  logic [TILE-1:0][DATA_W-1:0]  w_data;
  logic                         o_valid;
  logic                         o_ready;
  logic [DATA_W-1:0]            o_data;
  logic [IDX_W-1:0]             o_idx;

  modport master (
    output w_valid, w_data, o_ready,
    input  w_ready, o_valid, o_data, o_idx
  );

  modport slave (
    input  w_valid, w_data, o_ready,
    output w_ready, o_valid, o_data, o_idx
  );
endinterface

// File: rtl/fcl_tile_stream_engine.sv
// Tiled fully-connected layer: streams TILE-wide weight slices into per-row accumulators,
// adds biases, then drains saturated (optionally ReLU'd) results one neuron per beat.
module fcl_tile_stream_engine #(
  parameter int IN_COUNT  = 60,
  parameter int OUT_COUNT = 50,
  parameter int TILE      = 20,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               relu_mode,
  input  logic [IN_COUNT-1:0][DATA_W-1:0]    inputs,
  input  logic [OUT_COUNT-1:0][DATA_W-1:0]   biases,
  fcl_tile_stream_engine_if.slave            bus,
  output logic                               busy,
  output logic                               done
);
  function automatic int bits_for(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NOB     = (OUT_COUNT + TILE - 1) / TILE;
  localparam int NIB     = (IN_COUNT + TILE - 1) / TILE;
  localparam int LAST_R  = OUT_COUNT - (NOB - 1) * TILE;
  localparam int IN_PAD  = NIB * TILE;
  localparam int OUT_PAD = NOB * TILE;
  localparam int OB_W    = bits_for(NOB);
  localparam int IB_W    = bits_for(NIB);
  localparam int ROW_W   = bits_for(TILE);
  localparam int IP_W    = bits_for(IN_PAD);
  localparam int OP_W    = bits_for(OUT_PAD);
  localparam int IDX_W   = $clog2(OUT_COUNT);

  localparam logic signed [ACC_W-1:0] SAT_HI =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_BIAS, S_DRAIN, S_DONE} state_t;

  state_t                    state, next_state;
  logic [OB_W-1:0]           ob;
  logic [IB_W-1:0]           ib;
  logic [ROW_W-1:0]          row;
  logic                      relu_q;
  logic signed [DATA_W-1:0]  in_pad [IN_PAD];
  logic signed [DATA_W-1:0]  b_pad  [OUT_PAD];
  logic signed [ACC_W-1:0]   acc    [TILE];

  logic                      last_row, last_ib, last_ob;
  logic [IP_W-1:0]           in_base;
  logic [OP_W-1:0]           b_base;
  logic signed [ACC_W-1:0]   dot;
  logic signed [ACC_W-1:0]   shifted;
  logic [DATA_W-1:0]         result;

  function automatic logic signed [ACC_W-1:0] mul_ext(logic signed [DATA_W-1:0] a,
                                                      logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] p;
    p = a * b;
    return ACC_W'(p);
  endfunction

  assign last_ob  = (ob == OB_W'(NOB - 1));
  assign last_ib  = (ib == IB_W'(NIB - 1));
  assign last_row = last_ob ? (row == ROW_W'(LAST_R - 1)) : (row == ROW_W'(TILE - 1));
  assign in_base  = IP_W'(ib * TILE);
  assign b_base   = OP_W'(ob * TILE);

  // Lanes past IN_COUNT read the zero padding, so their w_data never reaches the sum.
  always_comb begin
    dot = '0;
    for (int unsigned k = 0; k < TILE; k++)
      dot = dot + mul_ext(in_pad[in_base + IP_W'(k)], bus.w_data[k]);
  end

  always_comb begin
    shifted = acc[row] >>> FRAC_BITS;
    result  = shifted[DATA_W-1:0];
    if (shifted > SAT_HI)      result = SAT_HI[DATA_W-1:0];
    else if (shifted < SAT_LO) result = SAT_LO[DATA_W-1:0];
    if (relu_q && result[DATA_W-1]) result = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    busy        = (state != S_IDLE);
    done        = 1'b0;
    bus.w_ready = 1'b0;
    bus.o_valid = 1'b0;
    bus.o_data  = '0;
    bus.o_idx   = '0;
    case (state)
      S_IDLE:  if (start) next_state = S_MAC;
      S_MAC: begin
        bus.w_ready = 1'b1;
        if (bus.w_valid && last_ib && last_row) next_state = S_BIAS;
      end
      S_BIAS:  next_state = S_DRAIN;
      S_DRAIN: begin
        bus.o_valid = 1'b1;
        bus.o_data  = result;
        bus.o_idx   = IDX_W'(ob * TILE + row);
        if (bus.o_ready && last_row) next_state = last_ob ? S_DONE : S_MAC;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Padding slots of in_pad/b_pad are only ever written by reset, so they stay zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob     <= '0;
      ib     <= '0;
      row    <= '0;
      relu_q <= 1'b0;
      for (int unsigned i = 0; i < IN_PAD; i++)  in_pad[i] <= '0;
      for (int unsigned i = 0; i < OUT_PAD; i++) b_pad[i]  <= '0;
      for (int unsigned r = 0; r < TILE; r++)    acc[r]    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          relu_q <= relu_mode;
          ob     <= '0;
          ib     <= '0;
          row    <= '0;
          for (int unsigned i = 0; i < IN_COUNT; i++)  in_pad[i] <= inputs[i];
          for (int unsigned i = 0; i < OUT_COUNT; i++) b_pad[i]  <= biases[i];
          for (int unsigned r = 0; r < TILE; r++)      acc[r]    <= '0;
        end
        S_MAC: if (bus.w_valid) begin
          acc[row] <= acc[row] + dot;
          if (last_row) begin
            row <= '0;
            if (!last_ib) ib <= ib + IB_W'(1);
          end else begin
            row <= row + ROW_W'(1);
          end
        end
        S_BIAS: begin
          row <= '0;
          for (int unsigned r = 0; r < TILE; r++)
            acc[r] <= acc[r] + (ACC_W'(b_pad[b_base + OP_W'(r)]) <<< FRAC_BITS);
        end
        S_DRAIN: if (bus.o_ready) begin
          if (last_row) begin
            row <= '0;
            if (!last_ob) begin
              ob <= ob + OB_W'(1);
              ib <= '0;
              for (int unsigned r = 0; r < TILE; r++) acc[r] <= '0;
            end
          end else begin
            row <= row + ROW_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fcl_tile_stream_engine.sv
// Scoreboard bench: golden per-neuron model queued at start, popped on each result beat.
module tb_fcl_tile_stream_engine;
  localparam int IN  = 60;
  localparam int OUT = 50;
  localparam int T   = 20;
  localparam int DW  = 16;
  localparam int NIB = (IN + T - 1) / T;
  localparam int NOB = (OUT + T - 1) / T;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, relu_mode, busy, done;
  logic [IN-1:0][DW-1:0]  inputs;
  logic [OUT-1:0][DW-1:0] biases;
  fcl_tile_stream_engine_if #(.DATA_W(DW), .TILE(T), .OUT_COUNT(OUT)) bus ();

  fcl_tile_stream_engine #(
    .IN_COUNT(IN), .OUT_COUNT(OUT), .TILE(T), .DATA_W(DW), .FRAC_BITS(8), .ACC_W(40)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .relu_mode(relu_mode),
    .inputs(inputs), .biases(biases), .bus(bus), .busy(busy), .done(done)
  );

  logic s_start, s_relu, s_busy, s_done;
  logic [3:0][DW-1:0] s_inputs;
  logic [2:0][DW-1:0] s_biases;
  fcl_tile_stream_engine_if #(.DATA_W(DW), .TILE(2), .OUT_COUNT(3)) s_bus ();

  fcl_tile_stream_engine #(
    .IN_COUNT(4), .OUT_COUNT(3), .TILE(2), .DATA_W(DW), .FRAC_BITS(8), .ACC_W(40)
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .relu_mode(s_relu),
    .inputs(s_inputs), .biases(s_biases), .bus(s_bus), .busy(s_busy), .done(s_done)
  );

  typedef struct {
    logic [5:0]    idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;
  bit   stop;

  logic signed [DW-1:0] in_v [IN];
  logic signed [DW-1:0] w_m  [OUT][IN];
  logic signed [DW-1:0] b_v  [OUT];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int rows(int ob);
    return (OUT - ob * T < T) ? OUT - ob * T : T;
  endfunction

  function automatic logic [DW-1:0] model(int j, bit relu);
    longint a, s;
    a = 0;
    for (int i = 0; i < IN; i++) a += longint'(in_v[i]) * longint'(w_m[j][i]);
    a += longint'(b_v[j]) * 256;
    s = a >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return DW'(s);
  endfunction

  task automatic fill(input logic [DW-1:0] iv, input logic [DW-1:0] wv, input logic [DW-1:0] bv);
    for (int i = 0; i < IN; i++) in_v[i] = iv;
    for (int j = 0; j < OUT; j++) begin
      b_v[j] = bv;
      for (int i = 0; i < IN; i++) w_m[j][i] = wv;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < IN; i++) in_v[i] = DW'($urandom_range(0, 1023)) - 16'sd512;
    for (int j = 0; j < OUT; j++) begin
      b_v[j] = DW'($urandom_range(0, 4095)) - 16'sd2048;
      for (int i = 0; i < IN; i++) w_m[j][i] = DW'($urandom_range(0, 1023)) - 16'sd512;
    end
  endtask

  task automatic run_layer(input bit relu, input bit gaps, input bit stall,
                           input bit abort_mid, input bit poke_start);
    int done_before;
    for (int i = 0; i < IN; i++)  inputs[i] = in_v[i];
    for (int j = 0; j < OUT; j++) biases[j] = b_v[j];
    q.delete();
    for (int j = 0; j < OUT; j++) q.push_back('{idx: 6'(j), data: model(j, relu)});
    stop = 1'b0;
    done_before = done_cnt;
    @(negedge clk);
    start = 1'b1;
    relu_mode = relu;
    @(negedge clk);
    start = 1'b0;
    relu_mode = 1'b0;
    chk("busy_after_start", busy, 1);
    fork
      begin : driver
        int beats = 0;
        int waitc;
        for (int ob = 0; ob < NOB; ob++) begin
          if (stop) break;
          for (int b = 0; b < NIB * rows(ob); b++) begin
            int ib, rw;
            ib = b / rows(ob);
            rw = b % rows(ob);
            @(negedge clk);
            start = 1'b0;
            if (gaps && $urandom_range(0, 3) == 0) begin
              bus.w_valid = 1'b0;
              repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            for (int k = 0; k < T; k++) bus.w_data[k] = w_m[ob * T + rw][ib * T + k];
            bus.w_valid = 1'b1;
            waitc = 0;
            while (!bus.w_ready && !stop) begin
              @(negedge clk);
              if (++waitc > 2000) begin
                chk("w_ready_timeout", 0, 1);
                stop = 1'b1;
              end
            end
            if (stop) break;
            beats++;
            if (poke_start && beats == 7) start = 1'b1;
            if (abort_mid && ob == 1 && b == 3) begin
              @(negedge clk);
              rst_n = 1'b0;
              #1;
              chk("abort_busy", busy, 0);
              chk("abort_w_ready", bus.w_ready, 0);
              chk("abort_o_valid", bus.o_valid, 0);
              stop = 1'b1;
              @(negedge clk);
              rst_n = 1'b1;
              break;
            end
            if (b == NIB * rows(ob) - 1) begin
              @(negedge clk);
              bus.w_valid = 1'b0;
              chk("mac_exit", bus.w_ready, 0);
            end
          end
        end
        bus.w_valid = 1'b0;
        start = 1'b0;
      end
      begin : monitor
        int got = 0, idle = 0, stall_left = 0;
        bit stalled = 1'b0;
        logic [DW-1:0] hold_d;
        logic [5:0]    hold_i;
        exp_t e;
        bus.o_ready = 1'b1;
        while (got < OUT && !stop) begin
          @(negedge clk);
          if (stop) break;
          if (stall_left > 0) begin
            chk("stall_valid", bus.o_valid, 1);
            chk("stall_data", bus.o_data, hold_d);
            chk("stall_idx", bus.o_idx, hold_i);
            stall_left--;
            bus.o_ready = (stall_left == 0);
          end else if (stall && !stalled && got == 25 && bus.o_valid) begin
            stalled = 1'b1;
            hold_d = bus.o_data;
            hold_i = bus.o_idx;
            stall_left = 5;
            bus.o_ready = 1'b0;
          end
          if (bus.o_valid) chk("w_o_exclusive", bus.w_ready, 0);
          if (bus.o_valid && bus.o_ready) begin
            if (q.size() == 0) begin
              chk("extra_beat", 1, 0);
            end else begin
              e = q.pop_front();
              chk("o_idx", bus.o_idx, e.idx);
              chk("o_data", bus.o_data, e.data);
            end
            got++;
            idle = 0;
          end else if (++idle > 3000) begin
            chk("o_valid_timeout", 0, 1);
            stop = 1'b1;
          end
        end
        if (!abort_mid && !stop) begin
          @(negedge clk);
          chk("done_pulse", done, 1);
          chk("done_busy", busy, 1);
          @(negedge clk);
          chk("done_clear", done, 0);
          chk("idle_busy", busy, 0);
          chk("queue_empty", q.size(), 0);
          chk("one_done", done_cnt - done_before, 1);
        end
      end
    join
    if (abort_mid) q.delete();
  endtask

  initial begin
    int nb, k, cyc;
    rst_n = 1'b0;
    start = 1'b0;
    relu_mode = 1'b0;
    inputs = '0;
    biases = '0;
    bus.w_valid = 1'b0;
    bus.w_data = '0;
    bus.o_ready = 1'b0;
    s_start = 1'b0;
    s_relu = 1'b0;
    s_inputs = '0;
    s_biases = '0;
    s_bus.w_valid = 1'b0;
    s_bus.w_data = '0;
    s_bus.o_ready = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_w_ready", bus.w_ready, 0);
    chk("rst_o_valid", bus.o_valid, 0);
    chk("rst_o_data", bus.o_data, 0);
    chk("rst_o_idx", bus.o_idx, 0);
    chk("rst_s_busy", s_busy, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // 4x3 layer on 2-lane tiles: every result is 4 * (1.0 * 1.0) = 0x0400
    for (int i = 0; i < 4; i++) s_inputs[i] = 16'h0100;
    for (int i = 0; i < 2; i++) s_bus.w_data[i] = 16'h0100;
    s_bus.o_ready = 1'b1;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_bus.w_valid = 1'b1;
    nb = 0;
    k = 0;
    cyc = 0;
    while (k < 3 && cyc < 200) begin
      if (s_bus.w_ready) nb++;
      if (s_bus.o_valid) begin
        chk("s_o_idx", s_bus.o_idx, k);
        chk("s_o_data", s_bus.o_data, 16'h0400);
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    s_bus.w_valid = 1'b0;
    chk("s_outputs", k, 3);
    chk("s_weight_beats", nb, 6);
    chk("s_done_pulse", s_done, 1);
    @(negedge clk);
    chk("s_done_clear", s_done, 0);
    chk("s_idle", s_busy, 0);

    fill(16'h7FFF, 16'h7FFF, 16'h0000);
    run_layer(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    fill(16'h7FFF, 16'h8001, 16'h0000);
    run_layer(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_layer(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    fill(16'h7FFF, 16'h0000, 16'h0080);
    run_layer(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    fill(16'h7FFF, 16'h0000, 16'hFF00);
    run_layer(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    fill_rand();
    run_layer(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    fill_rand();
    run_layer(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    fill_rand();
    run_layer(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
